// File: rtl/iq_mag_demod_if.sv
// ---------------------------------------------------------------------------
// iq_mag_demod_if
//   Result handshake between the IQ magnitude demodulator (producer) and
//   whatever consumes its results.
//
//   Signals:
//     value   [ACC_W] demodulated result, valid while rdy is high
//     rdy             an unconsumed result is being presented
//     overrun         sticky: an unconsumed result was overwritten
//     ack             consumer accepts the presented result
//
//   Modports:
//     master  producer side (drives value/rdy/overrun, reads ack)
//     slave   consumer side (reads value/rdy/overrun, drives ack)
// ---------------------------------------------------------------------------
interface iq_mag_demod_if #(
  parameter int ACC_W = 12
);

  logic [ACC_W-1:0] value;
  logic             rdy;
  logic             overrun;
  logic             ack;

  modport master (
    output value,
    output rdy,
    output overrun,
    input  ack
  );

  modport slave (
    input  value,
    input  rdy,
    input  overrun,
    output ack
  );

endinterface

// File: rtl/iq_mag_demod.sv
// ---------------------------------------------------------------------------
// iq_mag_demod
//   Coherent demodulator for a 1-bit sampled signal. A 16-bit NCO generates
//   in-phase and quadrature square-wave codes. Each sample is correlated
//   against both codes (+1 on match, -1 on mismatch) over a window of
//   N = 2^WIN_LOG2 samples. At the end of every window the sums are
//   snapshotted and pushed through a short pipeline that turns them into a
//   magnitude estimate. The result is presented with a rdy/ack handshake.
//
//   Pipeline (one register per stage):
//     P1 snapshot of I/Q sums and mode
//     P2 absolute values
//     P3 mode combine (with saturation)
//     P4 output register (value/rdy/overrun)
//   rdy rises three edges after the edge that counts the window's last
//   sample.
//
//   Ports:
//     clk        clock, all state on rising edge
//     rst_in     asynchronous active-low reset
//     sig        1-bit input sample, one per clock
//     freq[16]   NCO increment, added to the phase accumulator every cycle
//     phase[16]  phase offset applied to both I and Q codes
//     mode[2]    0=|I|, 1=|I|+|Q|, 2=max+min/2, 3=signed I
//     restart    synchronous restart of NCO, correlators and window;
//                cancels results still in P1-P3
//     res        result handshake (value, rdy, overrun, ack)
//
//   Parameters:
//     ACC_W      signed accumulator width and output width
//                (must be >= WIN_LOG2+2)
//     WIN_LOG2   log2 of the integration window length
// ---------------------------------------------------------------------------
module iq_mag_demod #(
  parameter int ACC_W    = 12,
  parameter int WIN_LOG2 = 8
) (
  input  logic           clk,
  input  logic           rst_in,
  input  logic           sig,
  input  logic [15:0]    freq,
  input  logic [15:0]    phase,
  input  logic [1:0]     mode,
  input  logic           restart,
  iq_mag_demod_if.master res
);

  typedef enum logic [1:0] {
    MODE_ABS_I    = 2'd0,
    MODE_SUM      = 2'd1,
    MODE_MAXMIN   = 2'd2,
    MODE_SIGNED_I = 2'd3
  } mode_e;

  generate
    if (ACC_W < WIN_LOG2 + 2) begin : g_bad_width
      $error("iq_mag_demod: ACC_W must be at least WIN_LOG2+2");
    end
  endgenerate

  localparam logic signed [ACC_W-1:0] PLUS1  = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] MINUS1 = '1;

  // -------------------------------------------------------------------------
  // NCO and code generation
  // -------------------------------------------------------------------------
  logic [15:0] acc_q;
  logic [15:0] acc_d;
  logic [1:0]  ph_hi;
  logic        i_code;
  logic        q_code;

  // Only the top two bits of acc+phase are needed: adding 16'h4000 flips
  // bit 15 exactly when bit 14 is set, so q_code = bit15 ^ bit14.
  always_comb begin
    acc_d  = acc_q + freq;
    ph_hi  = 2'((acc_q + phase) >> 14);
    i_code = ph_hi[1];
    q_code = ph_hi[1] ^ ph_hi[0];
  end

  // -------------------------------------------------------------------------
  // Correlators and window counter
  // -------------------------------------------------------------------------
  logic signed [ACC_W-1:0] i_acc_q;
  logic signed [ACC_W-1:0] q_acc_q;
  logic signed [ACC_W-1:0] i_sum_d;
  logic signed [ACC_W-1:0] q_sum_d;
  logic [WIN_LOG2-1:0]     cnt_q;
  logic                    win_last;

  always_comb begin
    i_sum_d  = i_acc_q + ((sig == i_code) ? PLUS1 : MINUS1);
    q_sum_d  = q_acc_q + ((sig == q_code) ? PLUS1 : MINUS1);
    win_last = &cnt_q;
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      acc_q   <= '0;
      i_acc_q <= '0;
      q_acc_q <= '0;
      cnt_q   <= '0;
    end else if (restart) begin
      // The sample presented in the restart cycle is dropped.
      acc_q   <= '0;
      i_acc_q <= '0;
      q_acc_q <= '0;
      cnt_q   <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + 1'b1;
      // On the last sample the full sums go to the snapshot, and the
      // accumulators start clean so the next sample opens a new window.
      if (win_last) begin
        i_acc_q <= '0;
        q_acc_q <= '0;
      end else begin
        i_acc_q <= i_sum_d;
        q_acc_q <= q_sum_d;
      end
    end
  end

  // -------------------------------------------------------------------------
  // P1: snapshot of window sums and mode
  // -------------------------------------------------------------------------
  logic signed [ACC_W-1:0] i_s_q;
  logic signed [ACC_W-1:0] q_s_q;
  mode_e                   mode1_q;
  logic                    v1_q;

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      i_s_q   <= '0;
      q_s_q   <= '0;
      mode1_q <= MODE_ABS_I;
      v1_q    <= 1'b0;
    end else begin
      v1_q <= win_last && !restart;
      if (win_last && !restart) begin
        i_s_q   <= i_sum_d;
        q_s_q   <= q_sum_d;
        mode1_q <= mode_e'(mode);
      end
    end
  end

  // -------------------------------------------------------------------------
  // P2: absolute values (the most negative code maps to 2^(ACC_W-1),
  // which is correct when read as unsigned)
  // -------------------------------------------------------------------------
  logic [ACC_W-1:0]        i_abs_d;
  logic [ACC_W-1:0]        q_abs_d;
  logic [ACC_W-1:0]        i_abs_q;
  logic [ACC_W-1:0]        q_abs_q;
  logic signed [ACC_W-1:0] i_raw_q;
  mode_e                   mode2_q;
  logic                    v2_q;

  always_comb begin
    i_abs_d = i_s_q[ACC_W-1] ? ACC_W'(-i_s_q) : ACC_W'(i_s_q);
    q_abs_d = q_s_q[ACC_W-1] ? ACC_W'(-q_s_q) : ACC_W'(q_s_q);
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      i_abs_q <= '0;
      q_abs_q <= '0;
      i_raw_q <= '0;
      mode2_q <= MODE_ABS_I;
      v2_q    <= 1'b0;
    end else begin
      v2_q <= v1_q && !restart;
      if (v1_q) begin
        i_abs_q <= i_abs_d;
        q_abs_q <= q_abs_d;
        i_raw_q <= i_s_q;
        mode2_q <= mode1_q;
      end
    end
  end

  // -------------------------------------------------------------------------
  // P3: mode combine
  // -------------------------------------------------------------------------
  logic [ACC_W:0]   sum_w;
  logic [ACC_W:0]   mm_w;
  logic [ACC_W-1:0] mx;
  logic [ACC_W-1:0] mn;
  logic [ACC_W-1:0] res3_d;
  logic [ACC_W-1:0] res3_q;
  logic             v3_q;

  always_comb begin
    sum_w = {1'b0, i_abs_q} + {1'b0, q_abs_q};
    if (i_abs_q >= q_abs_q) begin
      mx = i_abs_q;
      mn = q_abs_q;
    end else begin
      mx = q_abs_q;
      mn = i_abs_q;
    end
    mm_w = {1'b0, mx} + {2'b00, mn[ACC_W-1:1]};

    res3_d = '0;
    case (mode2_q)
      MODE_ABS_I:    res3_d = i_abs_q;
      MODE_SUM:      res3_d = sum_w[ACC_W] ? '1 : sum_w[ACC_W-1:0];
      MODE_MAXMIN:   res3_d = mm_w[ACC_W]  ? '1 : mm_w[ACC_W-1:0];
      MODE_SIGNED_I: res3_d = ACC_W'(i_raw_q);
      default:       res3_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      res3_q <= '0;
      v3_q   <= 1'b0;
    end else begin
      v3_q <= v2_q && !restart;
      if (v2_q) begin
        res3_q <= res3_d;
      end
    end
  end

  // -------------------------------------------------------------------------
  // P4: output register and handshake
  // -------------------------------------------------------------------------
  logic [ACC_W-1:0] value_q;
  logic             rdy_q;
  logic             ovr_q;
  logic             load;

  // A result still in P3 on a restart edge has not reached P4 and is dropped.
  assign load = v3_q && !restart;

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      value_q <= '0;
      rdy_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (load) begin
      // A load wins over ack: the new value stays presented. overrun is
      // only raised when the old result was neither consumed nor acked.
      value_q <= res3_q;
      rdy_q   <= 1'b1;
      if (rdy_q && !res.ack) begin
        ovr_q <= 1'b1;
      end
    end else if (rdy_q && res.ack) begin
      rdy_q <= 1'b0;
      ovr_q <= 1'b0;
    end
  end

  assign res.value   = value_q;
  assign res.rdy     = rdy_q;
  assign res.overrun = ovr_q;

endmodule
